// File: rtl/mem_pkg.sv
// Shared memory-subsystem types: responder FSM states, cache controller state table, default line width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

   localparam int LINE_WIDTH_DEF = 128;

   // Main-memory responder states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } mem_state_t;

   // L1 cache controller states (shared table so both sides agree on encodings)
   typedef enum logic [2:0] {
      CC_IDLE      = 3'd0,
      CC_LOOKUP    = 3'd1,
      CC_WRITEBACK = 3'd2,
      CC_REFILL    = 3'd3,
      CC_RESPOND   = 3'd4
   } cc_state_t;

endpackage

// File: rtl/mem_line_array.sv
// Single-port line storage: synchronous write and registered read on one address.
// Latency: read data valid the cycle after the address is presented; writes land at the edge.
// Backpressure: none; one access per cycle, contents survive reset.
module mem_line_array #(
   parameter int ADDR_WIDTH = 10,
   parameter int LINE_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [LINE_WIDTH-1:0] wdata,
   output logic [LINE_WIDTH-1:0] rdata
);

   logic [LINE_WIDTH-1:0] lines [2**ADDR_WIDTH];

   // Write when enabled; read register tracks the addressed line every cycle
   always_ff @(posedge clk) begin
      if (we) begin
         lines[addr] <= wdata;
      end
      rdata <= lines[addr];
   end

endmodule

// File: rtl/main_memory_responder.sv
// Fixed-latency main memory model answering line read/write requests from the L1 controller.
// Latency: mem_ack pulses one cycle, registered after edge N+LATENCY for a request accepted at edge N.
// Backpressure: mem_busy high while a request is in flight; mem_cs is only sampled in IDLE.
module main_memory_responder
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int LINE_WIDTH = LINE_WIDTH_DEF,
   parameter int LATENCY    = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_cs,
   input  logic                  mem_we,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [LINE_WIDTH-1:0] mem_wdata,
   output logic [LINE_WIDTH-1:0] mem_rdata,
   output logic                  mem_ack,
   output logic                  mem_busy
);

   mem_state_t            state;
   mem_state_t            state_nxt;
   logic [7:0]            cnt;
   logic                  cap_we;
   logic [ADDR_WIDTH-1:0] cap_addr;
   logic [LINE_WIDTH-1:0] cap_wdata;
   logic                  accept;
   logic                  done;
   logic                  arr_we;
   logic [ADDR_WIDTH-1:0] arr_addr;
   logic [LINE_WIDTH-1:0] arr_rdata;

   assign accept = (state == IDLE) && mem_cs;
   // Last WAIT cycle: the next edge enters ACK and completes the access
   assign done   = (state == WAIT) && (cnt == 8'd0);

   // State register; reset wins over any request in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (mem_cs) state_nxt = WAIT;
         WAIT:    if (cnt == 8'd0) state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Latency counter: loaded on accept, counts down to zero in WAIT
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 8'd0;
      end else if (accept) begin
         cnt <= 8'(LATENCY - 1);
      end else if ((state == WAIT) && (cnt != 8'd0)) begin
         cnt <= cnt - 8'd1;
      end
   end

   // Request capture; inputs are ignored until the FSM is back in IDLE
   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         cap_we    <= mem_we;
         cap_addr  <= mem_addr;
         cap_wdata <= mem_wdata;
      end
   end

   // Read data: loaded only when a read completes, held otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_rdata <= '0;
      end else if (done && !cap_we) begin
         mem_rdata <= arr_rdata;
      end
   end

   // In IDLE the array looks at the live address so the line is already
   // registered by the first WAIT cycle, which covers LATENCY=1.
   assign arr_addr = (state == IDLE) ? mem_addr : cap_addr;
   // Reset aborts a pending write before it can commit
   assign arr_we   = done && cap_we && !rst;

   assign mem_ack  = (state == ACK);
   assign mem_busy = (state != IDLE);

   mem_line_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .LINE_WIDTH (LINE_WIDTH)
   ) u_lines (
      .clk   (clk),
      .we    (arr_we),
      .addr  (arr_addr),
      .wdata (cap_wdata),
      .rdata (arr_rdata)
   );

endmodule

// File: tb/tb_main_memory_responder.sv
module tb_main_memory_responder;

   localparam int AW   = 10;
   localparam int LW   = 128;
   localparam int LAT4 = 4;

   logic          clk = 1'b0;
   logic          rst;
   // LATENCY=4 instance
   logic          cs, we;
   logic [AW-1:0] addr;
   logic [LW-1:0] wdata, rdata;
   logic          ack, busy;
   // LATENCY=1 instance
   logic          cs1, we1;
   logic [AW-1:0] addr1;
   logic [LW-1:0] wdata1, rdata1;
   logic          ack1, busy1;

   int tests = 0;
   int fails = 0;

   // Reference model: line contents and the last completed read value
   logic [LW-1:0] ref_mem [int];
   int            written [$];
   logic [LW-1:0] exp_rdata;

   always #5 clk = ~clk;

   main_memory_responder #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .LATENCY(LAT4)) u_dut4 (
      .clk(clk), .rst(rst), .mem_cs(cs), .mem_we(we), .mem_addr(addr),
      .mem_wdata(wdata), .mem_rdata(rdata), .mem_ack(ack), .mem_busy(busy)
   );

   main_memory_responder #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst), .mem_cs(cs1), .mem_we(we1), .mem_addr(addr1),
      .mem_wdata(wdata1), .mem_rdata(rdata1), .mem_ack(ack1), .mem_busy(busy1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // While a request is in flight, either idle the bus or throw junk at it
   task automatic drive_busy(input bit scr);
      if (scr) begin
         cs    = 1'($urandom);
         we    = 1'($urandom);
         addr  = AW'($urandom);
         wdata = {$urandom, $urandom, $urandom, $urandom};
      end else begin
         cs = 1'b0;
      end
   endtask

   // One full request on the LATENCY=4 instance, checked cycle by cycle
   task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] d, input bit scr);
      cs = 1'b1; we = w; addr = a; wdata = d;
      tick();
      chk("accept_busy", LW'(busy), LW'(1));
      chk("accept_ack", LW'(ack), LW'(0));
      for (int i = 1; i < LAT4; i++) begin
         drive_busy(scr);
         tick();
         chk("wait_ack", LW'(ack), LW'(0));
         chk("wait_busy", LW'(busy), LW'(1));
      end
      drive_busy(scr);
      tick();
      if (w) begin
         ref_mem[int'(a)] = d;
         written.push_back(int'(a));
      end else begin
         exp_rdata = ref_mem[int'(a)];
      end
      chk("done_ack", LW'(ack), LW'(1));
      chk("done_busy", LW'(busy), LW'(1));
      chk(w ? "wr_ack_rdata_hold" : "rd_data", rdata, exp_rdata);
      drive_busy(scr);
      tick();
      chk("post_ack", LW'(ack), LW'(0));
      chk("post_busy", LW'(busy), LW'(0));
      chk("post_rdata", rdata, exp_rdata);
      cs = 1'b0;
   endtask

   localparam logic [LW-1:0] PRELOAD = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
   localparam logic [LW-1:0] PATTERN = 128'h0123456789ABCDEF_0123456789ABCDEF;
   localparam logic [LW-1:0] OLD010  = 128'h11112222_33334444_55556666_77778888;
   localparam logic [LW-1:0] NEW010  = 128'h99990000_AAAABBBB_CCCCDDDD_EEEEFFFF;

   initial begin
      logic [5:0]    exp_ack1;
      logic [5:0]    exp_busy1;
      logic [LW-1:0] d1;

      rst = 1'b1;
      cs = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      cs1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      exp_rdata = '0;
      tick();
      tick();
      chk("rst_ack", LW'(ack), LW'(0));
      chk("rst_busy", LW'(busy), LW'(0));
      chk("rst_rdata", rdata, '0);
      chk("rst_busy1", LW'(busy1), LW'(0));
      rst = 1'b0;
      tick();

      // Read latency against a preloaded line
      do_req(1'b1, 10'h005, PRELOAD, 1'b0);
      do_req(1'b0, 10'h005, '0, 1'b0);

      // Write then read at the top address; rdata must hold through the write ack
      do_req(1'b1, 10'h3FF, PATTERN, 1'b0);
      do_req(1'b0, 10'h3FF, '0, 1'b0);
      do_req(1'b0, 10'h005, '0, 1'b0);

      // Inputs thrashed during WAIT/ACK must not leak into the access
      do_req(1'b1, 10'h010, OLD010, 1'b1);
      do_req(1'b0, 10'h3FF, '0, 1'b1);
      do_req(1'b0, 10'h010, '0, 1'b0);

      // Reset during WAIT of a write aborts it
      cs = 1'b1; we = 1'b1; addr = 10'h010; wdata = NEW010;
      tick();
      cs = 1'b0;
      tick();
      chk("midrst_pre_busy", LW'(busy), LW'(1));
      rst = 1'b1;
      tick();
      exp_rdata = '0;
      chk("midrst_busy", LW'(busy), LW'(0));
      chk("midrst_ack", LW'(ack), LW'(0));
      chk("midrst_rdata", rdata, exp_rdata);
      rst = 1'b0;
      for (int i = 0; i < LAT4 + 2; i++) begin
         tick();
         chk("midrst_no_ack", LW'(ack), LW'(0));
      end
      do_req(1'b0, 10'h010, '0, 1'b0);

      // Reset and request in the same cycle: reset wins
      rst = 1'b1; cs = 1'b1; we = 1'b0; addr = 10'h005;
      tick();
      chk("rst_cs_busy", LW'(busy), LW'(0));
      rst = 1'b0; cs = 1'b0;
      tick();
      chk("rst_cs_busy2", LW'(busy), LW'(0));
      chk("rst_cs_ack2", LW'(ack), LW'(0));
      exp_rdata = '0;

      // Back-to-back on LATENCY=1 with cs held: write then read of the same line
      d1 = {$urandom, $urandom, $urandom, $urandom};
      cs1 = 1'b1; we1 = 1'b1; addr1 = 10'h123; wdata1 = d1;
      exp_ack1  = 6'b010010;
      exp_busy1 = 6'b011011;
      for (int e = 0; e < 6; e++) begin
         tick();
         if (e == 0) begin
            we1 = 1'b0;
            wdata1 = '0;
         end
         chk("b2b_ack", LW'(ack1), LW'(exp_ack1[e]));
         chk("b2b_busy", LW'(busy1), LW'(exp_busy1[e]));
         if (e == 4) begin
            chk("b2b_rdata", rdata1, d1);
            cs1 = 1'b0;
         end
      end

      // Randomized traffic against the model, with input thrashing
      for (int n = 0; n < 24; n++) begin
         if (written.size() == 0 || $urandom_range(0, 1) == 0) begin
            do_req(1'b1, AW'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
         end else begin
            do_req(1'b0, AW'(written[$urandom_range(0, written.size() - 1)]), '0, 1'($urandom));
         end
      end

      // Re-read every line touched so far
      foreach (written[i]) begin
         do_req(1'b0, AW'(written[i]), '0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/main_memory_responder.md
MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: line-index width; storage depth is 2^ADDR_WIDTH lines.
REQ-002 SHALL have parameter LINE_WIDTH, default 128: cache-line width in bits.
REQ-003 SHALL have parameter LATENCY, default 10: request-to-ack cycles; legal range 1..255.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port mem_cs, input, 1 bit: request strobe from the L1 cache controller.
REQ-007 SHALL have port mem_we, input, 1 bit: 1 = line write, 0 = line read.
REQ-008 SHALL have port mem_addr, input, ADDR_WIDTH bits: line index.
REQ-009 SHALL have port mem_wdata, input, LINE_WIDTH bits: write line data.
REQ-010 SHALL have port mem_rdata, output, LINE_WIDTH bits: read line data.
REQ-011 SHALL have port mem_ack, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port mem_busy, output, 1 bit: high while a request is in flight (WAIT or ACK).

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, ACK.
REQ-014 SHALL, in IDLE with mem_cs=1 at edge N, capture mem_we, mem_addr and mem_wdata, load cnt=LATENCY-1, and enter WAIT.
REQ-015 SHALL, in IDLE with mem_cs=0, remain in IDLE.
REQ-016 SHALL, in WAIT, enter ACK when cnt==0 and otherwise decrement cnt, so mem_ack is registered high after edge N+LATENCY.
REQ-017 SHALL hold mem_ack=1 for exactly one cycle (ACK state only), then return to IDLE.
REQ-018 SHALL ignore mem_cs, mem_we, mem_addr and mem_wdata changes in WAIT and ACK; only the captured values are used.
REQ-019 SHALL, for a read, load mem_rdata with line[captured addr] at the edge entering ACK, and hold mem_rdata until the next read completes.
REQ-020 SHALL, for a write, commit the captured data to line[captured addr] at the edge entering ACK, leaving mem_rdata unchanged.
REQ-021 SHALL sample mem_cs again first in IDLE, so the earliest next accept is edge N+LATENCY+2; a requester still holding mem_cs then issues a new request.
REQ-022 SHALL, when a read follows a write to the same address, return the newly written data.
REQ-023 SHALL use a cnt width of 8 bits with no wrap-around; cnt only ever counts down from LATENCY-1 to 0.

Reset
REQ-024 SHALL, at a rising edge with rst=1, force state=IDLE, cnt=0, mem_ack=0, mem_busy=0 and mem_rdata=0.
REQ-025 SHALL, when rst hits mid-request, abort the request: no ack is issued and a pending write is not committed.
REQ-026 SHALL NOT clear storage contents on reset.
REQ-027 SHALL give rst priority over mem_cs in the same cycle.

Structure
REQ-028 SHALL take the state encodings (IDLE/WAIT/ACK) and the default LINE_WIDTH from the shared package mem_pkg, alongside the cache controller state table.
REQ-029 SHALL place storage in one sub-module, mem_line_array: a single-port synchronous array with write-enable, address, write data and read data.

Verification
REQ-030 SHALL cover read latency: LATENCY=4, read addr 0x005 preloaded with 0xDEADBEEF_... accepted at edge 10 -> mem_ack high only after edge 14, mem_rdata equals the preload, mem_busy high for cycles 11-15.
REQ-031 SHALL cover write-then-read: write 0x0123..CDEF to addr 0x3FF, then read 0x3FF -> the read returns 0x0123..CDEF, and mem_rdata is unchanged during the write ack.
REQ-032 SHALL cover input stability: change mem_addr and mem_wdata every cycle during WAIT -> the captured addr/data are used and the stray values have no effect.
REQ-033 SHALL cover mid-request reset: rst asserted in WAIT of a write to 0x010 -> no mem_ack, FSM in IDLE next cycle, and a later read of 0x010 returns the old contents.
REQ-034 SHALL cover back-to-back requests with LATENCY=1 and mem_cs held high -> acks at edges N+1 and N+4, with one idle cycle between.
REQ-035 SHALL cover simultaneous rst=1 and mem_cs=1 in IDLE -> no request accepted and mem_busy stays 0.
